fetch_unit: RTL and testbench

//  Instruction fetch stage of the RISC core; sits directly upstream of the control unit.

---
 rtl/riscv_pkg.sv | 19 +
 rtl/next_pc_calc.sv | 47 ++++
 rtl/fetch_unit.sv | 144 ++++++++++++++
 tb/tb_fetch_unit.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared encodings for the fetch stage and the control unit
// Contents: pc_cnt next-PC select encodings, opcode field bounds, fetch FSM states.
package riscv_pkg;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_J   = 2'b10;
  localparam logic [1:0] PC_JR  = 2'b11;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/next_pc_calc.sv
// rtl/next_pc_calc.sv - combinational next-PC select and address adders
// Ports:
//   pc           in   address of the instruction currently in ir
//   jidx         in   ir[25:0], jump target word index
//   pc_cnt       in   next-PC select (seq / branch / jump / jump-reg)
//   branch_taken in   qualifies the branch select
//   br_offset    in   signed word offset for branches
//   rs_val       in   register value for jump-reg
//   next_pc      out  selected next address (wraps mod 2^ADDR_W)
module next_pc_calc
  import riscv_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [25:0]       jidx,
  input  logic [1:0]        pc_cnt,
  input  logic              branch_taken,
  input  logic [15:0]       br_offset,
  input  logic [ADDR_W-1:0] rs_val,
  output logic [ADDR_W-1:0] next_pc
);

  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] br_disp;
  logic [ADDR_W-1:0] jmp_hi_mask;
  logic [ADDR_W-1:0] jmp_lo;

  assign pc_plus4    = pc + ADDR_W'(4);
  // Word offset becomes a byte displacement: sign-extend, then shift left by 2.
  assign br_disp     = {{(ADDR_W-18){br_offset[15]}}, br_offset, 2'b00};
  // Jumps keep the region bits of pc+4 above the 28-bit jump reach.
  assign jmp_hi_mask = {{(ADDR_W-28){1'b1}}, {28{1'b0}}};
  assign jmp_lo      = {{(ADDR_W-28){1'b0}}, jidx, 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    case (pc_cnt)
      PC_SEQ:  next_pc = pc_plus4;
      PC_BR:   next_pc = branch_taken ? (pc_plus4 + br_disp) : pc_plus4;
      PC_J:    next_pc = (pc_plus4 & jmp_hi_mask) | jmp_lo;
      PC_JR:   next_pc = rs_val & ~ADDR_W'(3);
      default: next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, imem req/ack, IR, next-PC update
// Optional feature macro: FETCH_PERF_CNT_EN (adds perf_fetched / perf_stall counters).
// Ports:
//   clk, rst_n              clock, async active-low reset
//   imem_req/addr/ack/rdata instruction memory handshake (req held until ack)
//   instr_valid/ready       ir handoff to decode
//   ir, opcode, pc          instruction register, its opcode field and address
//   pc_cnt, branch_taken,
//   br_offset, rs_val       next-PC controls, sampled at the accept edge
//   perf_fetched/stall      (FETCH_PERF_CNT_EN only) accept and stall counters
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] ir,
  output logic [5:0]        opcode,
  output logic [ADDR_W-1:0] pc,
  input  logic [1:0]        pc_cnt,
  input  logic              branch_taken,
  input  logic [15:0]       br_offset,
  input  logic [ADDR_W-1:0] rs_val
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_stall
`endif
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              req_q, req_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] next_pc;

  next_pc_calc #(.ADDR_W(ADDR_W)) u_next_pc (
    .pc           (pc_q),
    .jidx         (ir_q[25:0]),
    .pc_cnt       (pc_cnt),
    .branch_taken (branch_taken),
    .br_offset    (br_offset),
    .rs_val       (rs_val),
    .next_pc      (next_pc)
  );

  // req/valid are registered alongside the state so they change on the same edge.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    req_d   = req_q;
    valid_d = valid_q;
    case (state_q)
      S_BOOT: begin
        state_d = S_REQ;
        req_d   = 1'b1;
      end
      S_REQ: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          valid_d = 1'b1;
          req_d   = 1'b0;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (instr_ready) begin
          pc_d    = next_pc;
          valid_d = 1'b0;
          req_d   = 1'b1;
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_BOOT;
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      req_q   <= req_d;
      valid_q <= valid_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr_valid = valid_q;
  assign ir          = ir_q;
  assign opcode      = ir_q[OPC_MSB:OPC_LSB];
  assign pc          = pc_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_stall_q, perf_stall_d;
  logic        accept, stall;

  assign accept = (state_q == S_HOLD) && instr_ready;
  assign stall  = ((state_q == S_REQ) && !imem_ack) ||
                  ((state_q == S_HOLD) && !instr_ready);

  always_comb begin
    perf_fetched_d = perf_fetched_q + 32'(accept);
    perf_stall_d   = perf_stall_q + 32'(stall);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_stall_q   <= perf_stall_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] ir;
  logic [5:0]  opcode;
  logic [31:0] pc;
  logic [1:0]  pc_cnt;
  logic        branch_taken;
  logic [15:0] br_offset;
  logic [31:0] rs_val;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  fetch_unit #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'h100)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .ir           (ir),
    .opcode       (opcode),
    .pc           (pc),
    .pc_cnt       (pc_cnt),
    .branch_taken (branch_taken),
    .br_offset    (br_offset),
    .rs_val       (rs_val)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_stall   (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] cur_ir, cur_pc;
  int unsigned fetched_m, stall_m;

  typedef struct {
    logic [31:0] pc0;
    logic [31:0] word;
    logic [1:0]  cnt;
    logic        tk;
    logic [15:0] off;
    logic [31:0] rs;
    logic [31:0] exp_next;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Next address from the architectural rules, in plain 32-bit arithmetic.
  function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [31:0] w,
                                           input logic [1:0] c, input logic tk,
                                           input logic [15:0] off, input logic [31:0] rs);
    int signed disp;
    logic [31:0] seq;
    disp = int'($signed(off));
    seq  = p + 32'd4;
    case (c)
      2'd0:    return seq;
      2'd1:    return tk ? seq + 32'(disp * 4) : seq;
      2'd2:    return (seq & 32'hF000_0000) | ((w % 32'h0400_0000) * 32'd4);
      default: return rs - (rs % 32'd4);
    endcase
  endfunction

  task automatic do_fetch(input logic [31:0] exp_addr, input logic [31:0] word,
                          input int waits, input logic rwa);
    int n = 0;
    while (imem_req !== 1'b1 && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    chk("req_up", imem_req, 1);
    chk("fetch_addr", imem_addr, exp_addr);
    chk("valid_lo_in_req", instr_valid, 0);
    for (int i = 0; i < waits; i++) begin
      instr_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      chk("wait_req", imem_req, 1);
      chk("wait_valid", instr_valid, 0);
    end
    imem_ack    = 1'b1;
    imem_rdata  = word;
    instr_ready = rwa;
    @(posedge clk); #1;
    imem_ack    = 1'b0;
    instr_ready = 1'b0;
    imem_rdata  = $urandom;
    chk("ack_valid", instr_valid, 1);
    chk("ack_ir", ir, word);
    chk("ack_opcode", opcode, 32'(word[31:26]));
    chk("ack_pc", pc, exp_addr);
    chk("ack_req_lo", imem_req, 0);
    cur_ir  = word;
    cur_pc  = exp_addr;
    stall_m += waits;
  endtask

  task automatic do_accept(input logic [1:0] cnt, input logic tk, input logic [15:0] off,
                           input logic [31:0] rs, input int hold);
    for (int i = 0; i < hold; i++) begin
      instr_ready = 1'b0;
      imem_ack    = 1'b1;
      imem_rdata  = ~cur_ir;
      pc_cnt      = 2'($urandom);
      @(posedge clk); #1;
      chk("hold_valid", instr_valid, 1);
      chk("hold_ir", ir, cur_ir);
      chk("hold_pc", pc, cur_pc);
      chk("hold_req", imem_req, 0);
    end
    imem_ack     = 1'b0;
    pc_cnt       = cnt;
    branch_taken = tk;
    br_offset    = off;
    rs_val       = rs;
    instr_ready  = 1'b1;
    @(posedge clk); #1;
    instr_ready  = 1'b0;
    pc_cnt       = 2'($urandom);
    rs_val       = $urandom;
    br_offset    = 16'($urandom);
    branch_taken = 1'($urandom);
    chk("acc_valid_lo", instr_valid, 0);
    chk("acc_req_up", imem_req, 1);
    stall_m   += hold;
    fetched_m++;
  endtask

  initial begin
    logic [31:0] mpc, w, rs;
    logic [1:0]  c;
    logic        tk;
    logic [15:0] off;

    tbl[0] = '{32'h0000_0200, 32'h1000_0000, 2'b01, 1'b1, 16'hFFFE, 32'h0, 32'h0000_01FC};
    tbl[1] = '{32'h0000_0200, 32'h1000_0000, 2'b01, 1'b0, 16'hFFFE, 32'h0, 32'h0000_0204};
    tbl[2] = '{32'h1000_0000, 32'h0800_0040, 2'b10, 1'b0, 16'h0,    32'h0, 32'h1000_0100};
    tbl[3] = '{32'h1000_0000, 32'h0000_0000, 2'b11, 1'b0, 16'h0,    32'h303, 32'h0000_0300};
    tbl[4] = '{32'hFFFF_FFFC, 32'h0000_0000, 2'b00, 1'b1, 16'h1234, 32'h0, 32'h0000_0000};
    tbl[5] = '{32'h0000_0200, 32'h1000_0000, 2'b01, 1'b1, 16'h7FFF, 32'h0, 32'h0002_0200};
    tbl[6] = '{32'hF000_0010, 32'h0BFF_FFFF, 2'b10, 1'b0, 16'h0,    32'h0, 32'hFFFF_FFFC};

    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
    pc_cnt = 2'b00; branch_taken = 1'b0; br_offset = '0; rs_val = '0;
    fetched_m = 0; stall_m = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", imem_req, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_pc", pc, 32'h100);
    chk("rst_ir", ir, 0);
    chk("rst_opcode", opcode, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("boot_req", imem_req, 1);

    // Sequential fetch with zero-wait memory and immediate accept.
    do_fetch(32'h100, 32'h2001_0001, 0, 1'b0);
    do_accept(2'b00, 1'b0, 16'h0, 32'h0, 0);
    do_fetch(32'h104, 32'h2002_0002, 0, 1'b1);
    do_accept(2'b00, 1'b0, 16'h0, 32'h0, 0);
    do_fetch(32'h108, 32'h8C00_0000, 0, 1'b0);
    chk("opc_lw", opcode, 32'h23);
    do_accept(2'b11, 1'b0, 16'h0, tbl[0].pc0, 5);

    for (int i = 0; i < 7; i++) begin
      do_fetch(tbl[i].pc0, tbl[i].word, 1, 1'b0);
      do_accept(tbl[i].cnt, tbl[i].tk, tbl[i].off, tbl[i].rs, 1);
      chk("tbl_next", imem_addr, tbl[i].exp_next);
      do_fetch(tbl[i].exp_next, 32'h0, 0, 1'b0);
      do_accept(2'b11, 1'b0, 16'h0, (i < 6) ? tbl[i + 1].pc0 : 32'h0000_0400, 0);
    end

    // Reset while a request is outstanding and memory is acking.
    chk("pre_rst_req", imem_req, 1);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    rst_n = 1'b0;
    #1;
    chk("midrst_req", imem_req, 0);
    chk("midrst_valid", instr_valid, 0);
    chk("midrst_pc", pc, 32'h100);
    chk("midrst_ir", ir, 0);
    imem_ack = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    fetched_m = 0; stall_m = 0;
`ifdef FETCH_PERF_CNT_EN
    chk("perf_rst_fetched", perf_fetched, 0);
    chk("perf_rst_stall", perf_stall, 0);
`endif

    // Three accepts, two ack-wait cycles each.
    do_fetch(32'h100, 32'h0000_0001, 2, 1'b0);
    do_accept(2'b00, 1'b0, 16'h0, 32'h0, 0);
    do_fetch(32'h104, 32'h0000_0002, 2, 1'b0);
    do_accept(2'b00, 1'b0, 16'h0, 32'h0, 0);
    do_fetch(32'h108, 32'h0000_0003, 2, 1'b0);
    do_accept(2'b00, 1'b0, 16'h0, 32'h0, 0);
`ifdef FETCH_PERF_CNT_EN
    chk("perf3_fetched", perf_fetched, 3);
    chk("perf3_stall", perf_stall, 6);
`endif

    // Randomized traffic against the reference model.
    mpc = 32'h10C;
    for (int k = 0; k < 40; k++) begin
      w   = $urandom;
      c   = 2'($urandom);
      tk  = 1'($urandom);
      off = 16'($urandom);
      rs  = $urandom;
      do_fetch(mpc, w, int'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0));
      do_accept(c, tk, off, rs, int'($urandom_range(0, 3)));
      mpc = ref_next(mpc, w, c, tk, off, rs);
    end
    do_fetch(mpc, 32'hFFFF_FFFF, 1, 1'b0);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetched_final", perf_fetched, fetched_m);
    chk("perf_stall_final", perf_stall, stall_m);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
